spi_word_feeder: RTL

Upstream stage for the 14-bit SPI word serializer. It buffers words from the control logic in a small FIFO and presents them one at a time on the serializer's parallel input. The serializer starts a frame whenever its input word changes and drops its ready signal for the whole frame. This block paces presentation on that ready signal, enforces an inter-frame gap, and drops words equal to the last presented word, since those would never launch a frame.

---
 rtl/spi_word_feeder_if.sv | 26 ++
 rtl/spi_word_feeder.sv | 95 +++++++++
 2 files changed

// File: rtl/spi_word_feeder_if.sv
// spi_word_feeder_if: write-side and serializer-side signals of the SPI word feeder
interface spi_word_feeder_if #(
  parameter int DATA_W     = 14,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic              i_Clr;
  logic [DATA_W-1:0] i_Wr_Data;
  logic              i_Wr_Valid;
  logic              o_Wr_Ready;
  logic              i_TX_Ready;
  logic [DATA_W-1:0] o_TX_Word;
  logic              o_Busy;
  logic [LW-1:0]     o_Fifo_Level;
  logic              o_Dup_Drop;
  logic              o_Overflow;
  logic              o_Err;
  modport slave (
    input  i_Clr, i_Wr_Data, i_Wr_Valid, i_TX_Ready,
    output o_Wr_Ready, o_TX_Word, o_Busy, o_Fifo_Level, o_Dup_Drop, o_Overflow, o_Err
  );
  modport master (
    output i_Clr, i_Wr_Data, i_Wr_Valid, i_TX_Ready,
    input  o_Wr_Ready, o_TX_Word, o_Busy, o_Fifo_Level, o_Dup_Drop, o_Overflow, o_Err
  );
endinterface

// File: rtl/spi_word_feeder.sv
// spi_word_feeder: FIFO-buffered, ready-paced word presenter for the SPI serializer
module spi_word_feeder #(
  parameter int DATA_W        = 14,
  parameter int FIFO_DEPTH    = 8,
  parameter int GAP_CLKS      = 2,
  parameter int START_TIMEOUT = 4
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  spi_word_feeder_if.slave bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = START_TIMEOUT > GAP_CLKS ? START_TIMEOUT : GAP_CLKS;
  localparam int CW   = $clog2(CMAX + 1) < 1 ? 1 : $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, GAP} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic              wr_rdy_q, dup_q, ovf_q, err_q;
  logic              push, pop, dup, err_set;
  logic [DATA_W-1:0] head;
  assign head    = mem_q[rd_ptr_q];
  assign push    = bus.i_Wr_Valid & wr_rdy_q;
  assign pop     = (state_q == IDLE) && (level_q != '0) && bus.i_TX_Ready;
  assign dup     = pop && (head == tx_word_q);
  assign level_d = level_q + LW'(push) - LW'(pop);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_word_d = tx_word_q;
    err_set   = 1'b0;
    case (state_q)
      IDLE:
        if (pop && !dup) begin
          tx_word_d = head;
          cnt_d     = CW'(START_TIMEOUT);
          state_d   = WAIT_START;
        end
      WAIT_START:
        if (!bus.i_TX_Ready) state_d = WAIT_DONE;
        else if (cnt_q <= CW'(1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q - CW'(1);
      WAIT_DONE:
        if (bus.i_TX_Ready) begin
          state_d = GAP_CLKS == 0 ? IDLE : GAP;
          cnt_d   = CW'(GAP_CLKS);
        end
      GAP: begin
        state_d = cnt_q <= CW'(1) ? IDLE : GAP;
        cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // storage needs no reset: occupancy is governed entirely by the pointers and level
  always_ff @(posedge i_Clk)
    if (push) mem_q[wr_ptr_q] <= bus.i_Wr_Data;
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      tx_word_q <= '0;
      wr_rdy_q  <= 1'b1;
      dup_q     <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_q + AW'(push);
      rd_ptr_q  <= rd_ptr_q + AW'(pop);
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      tx_word_q <= tx_word_d;
      wr_rdy_q  <= level_d != LW'(FIFO_DEPTH);
      dup_q     <= dup;
      ovf_q     <= (bus.i_Wr_Valid & ~wr_rdy_q) | (ovf_q & ~bus.i_Clr);
      err_q     <= err_set | (err_q & ~bus.i_Clr);
    end
  assign bus.o_Wr_Ready   = wr_rdy_q;
  assign bus.o_TX_Word    = tx_word_q;
  assign bus.o_Busy       = (state_q != IDLE) || (level_q != '0);
  assign bus.o_Fifo_Level = level_q;
  assign bus.o_Dup_Drop   = dup_q;
  assign bus.o_Overflow   = ovf_q;
  assign bus.o_Err        = err_q;
endmodule
